// File: rtl/psram_line_arbiter.sv
// Purpose : shares one QSPI PSRAM line controller between the CPU cache (line read/write)
//           and video refresh (line read), sequencing the mem_rd/mem_wr + busy handshake.
// Latency : request seen in IDLE -> mem_rd/mem_wr next cycle; ack 1 cycle after busy falls.
// Backpressure: requests are level-held and only sampled in IDLE, so nothing is lost while
//           a transfer is in flight. The controller stalls us by holding busy low (init).
//
// Ports:
//   mem_clk, reset           clock, synchronous active-high reset (shared with controller)
//   cpu_rd/cpu_wr/cpu_addr   CPU line fill / write-back request (level) and line address
//   cpu_line_rdata           CPU write-back buffer data, passed through as ctl_cache_rdata
//   cpu_ack, vid_ack         one-cycle completion pulses
//   vid_rd/vid_addr          video line-fetch request (level) and line address
//   cpu_buf_we, vid_buf_we   line-buffer write strobes routed from the controller
//   mem_rd/mem_wr/raddr/waddr  command to the controller
//   rd_busy/wr_busy          controller transfer-in-progress flags
//   ctl_cache_en/we          controller line-buffer port strobes
//   grant                    00 none, 01 CPU, 10 video
//   arb_err                  sticky ISSUE timeout flag
//
// Build option: define ARB_TIMEOUT_EN to enable the ISSUE-state watchdog (TIMEOUT_CYCLES).
// Without it arb_err is tied low and ISSUE waits for the controller indefinitely.

module psram_line_arbiter #(
    parameter int MAX_VID_RUN    = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic         mem_clk,
    input  logic         reset,
    input  logic         cpu_rd,
    input  logic         cpu_wr,
    input  logic [17:0]  cpu_addr,
    input  logic [127:0] cpu_line_rdata,
    output logic         cpu_ack,
    input  logic         vid_rd,
    input  logic [17:0]  vid_addr,
    output logic         vid_ack,
    output logic         cpu_buf_we,
    output logic         vid_buf_we,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [17:0]  raddr,
    output logic [17:0]  waddr,
    input  logic         rd_busy,
    input  logic         wr_busy,
    input  logic         ctl_cache_en,
    input  logic         ctl_cache_we,
    output logic [127:0] ctl_cache_rdata,
    output logic [1:0]   grant,
    output logic         arb_err
);

    if (MAX_VID_RUN < 1 || MAX_VID_RUN > 15) begin : g_bad_max_vid_run
        $error("psram_line_arbiter: MAX_VID_RUN must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32767) begin : g_bad_timeout
        $error("psram_line_arbiter: TIMEOUT_CYCLES must fit the 15-bit counter");
    end

    localparam logic [3:0] MAX_RUN = 4'(MAX_VID_RUN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        mem_rd_nxt, mem_wr_nxt;
    logic        cpu_ack_nxt, vid_ack_nxt;
    logic [17:0] raddr_nxt, waddr_nxt;
    logic [1:0]  grant_nxt;
    logic [3:0]  vid_run, vid_run_nxt;
    logic        busy;
    logic        cpu_req;
    logic        vid_win;
    logic        timeout_hit;

    assign busy    = rd_busy | wr_busy;
    assign cpu_req = cpu_rd | cpu_wr;
    // Video normally wins; a pending CPU request only gets in once video has had
    // MAX_VID_RUN consecutive grants.
    assign vid_win = vid_rd & (~cpu_req | (vid_run < MAX_RUN));

    // Line-buffer port routing: strobes reach only the current owner's buffer.
    assign cpu_buf_we      = ctl_cache_en & ctl_cache_we & (grant == 2'b01);
    assign vid_buf_we      = ctl_cache_en & ctl_cache_we & (grant == 2'b10);
    assign ctl_cache_rdata = cpu_line_rdata;

    always_comb begin
        state_nxt   = state;
        mem_rd_nxt  = mem_rd;
        mem_wr_nxt  = mem_wr;
        raddr_nxt   = raddr;
        waddr_nxt   = waddr;
        grant_nxt   = grant;
        cpu_ack_nxt = 1'b0;
        vid_ack_nxt = 1'b0;
        vid_run_nxt = vid_run;

        case (state)
            S_IDLE: begin
                if (!cpu_req) begin
                    vid_run_nxt = 4'd0;
                end
                if (vid_win) begin
                    grant_nxt  = 2'b10;
                    raddr_nxt  = vid_addr;
                    mem_rd_nxt = 1'b1;
                    state_nxt  = S_ISSUE;
                    if (cpu_req && vid_run != 4'hF) begin
                        vid_run_nxt = vid_run + 4'd1;
                    end
                end else if (cpu_req) begin
                    grant_nxt   = 2'b01;
                    vid_run_nxt = 4'd0;
                    state_nxt   = S_ISSUE;
                    // Write-back goes first so a dirty line is out before its refill.
                    if (cpu_wr) begin
                        waddr_nxt  = cpu_addr;
                        mem_wr_nxt = 1'b1;
                    end else begin
                        raddr_nxt  = cpu_addr;
                        mem_rd_nxt = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                if (busy) begin
                    mem_rd_nxt = 1'b0;
                    mem_wr_nxt = 1'b0;
                    state_nxt  = S_BUSY;
                end else if (timeout_hit) begin
                    // Give up on the controller but still complete the handshake so the
                    // requester is not left hanging.
                    mem_rd_nxt  = 1'b0;
                    mem_wr_nxt  = 1'b0;
                    state_nxt   = S_DONE;
                    cpu_ack_nxt = (grant == 2'b01);
                    vid_ack_nxt = (grant == 2'b10);
                end
            end

            S_BUSY: begin
                if (!busy) begin
                    state_nxt   = S_DONE;
                    cpu_ack_nxt = (grant == 2'b01);
                    vid_ack_nxt = (grant == 2'b10);
                end
            end

            S_DONE: begin
                // Ack is high this cycle; the requester drops its level here, and IDLE
                // samples fresh on the following cycle.
                grant_nxt = 2'b00;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt  = S_IDLE;
                mem_rd_nxt = 1'b0;
                mem_wr_nxt = 1'b0;
                grant_nxt  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state   <= S_IDLE;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            raddr   <= 18'd0;
            waddr   <= 18'd0;
            grant   <= 2'b00;
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            vid_run <= 4'd0;
        end else begin
            state   <= state_nxt;
            mem_rd  <= mem_rd_nxt;
            mem_wr  <= mem_wr_nxt;
            raddr   <= raddr_nxt;
            waddr   <= waddr_nxt;
            grant   <= grant_nxt;
            cpu_ack <= cpu_ack_nxt;
            vid_ack <= vid_ack_nxt;
            vid_run <= vid_run_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [14:0] TO_LAST = 15'(TIMEOUT_CYCLES - 1);

    logic [14:0] to_cnt;

    // to_cnt holds (ISSUE cycles elapsed - 1), so the hit fires on the
    // TIMEOUT_CYCLES-th cycle spent waiting for busy.
    assign timeout_hit = (to_cnt == TO_LAST);

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            to_cnt  <= 15'd0;
            arb_err <= 1'b0;
        end else begin
            if (state == S_ISSUE && !busy && !timeout_hit) begin
                to_cnt <= to_cnt + 15'd1;
            end else begin
                to_cnt <= 15'd0;
            end
            if (state == S_ISSUE && !busy && timeout_hit) begin
                arb_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign arb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_psram_line_arbiter.sv
// Directed bench for psram_line_arbiter with a small behavioural controller model:
// busy rises the cycle after mem_rd/mem_wr is first seen, stays high busy_len cycles,
// and strobes the line-buffer port 4 times (write strobe only on reads).

module tb_psram_line_arbiter;

    localparam int TMO = 100;

    logic         mem_clk = 1'b0;
    logic         reset;
    logic         cpu_rd, cpu_wr, vid_rd;
    logic [17:0]  cpu_addr, vid_addr;
    logic [127:0] cpu_line_rdata;
    logic         cpu_ack, vid_ack, cpu_buf_we, vid_buf_we;
    logic         mem_rd, mem_wr;
    logic [17:0]  raddr, waddr;
    logic         rd_busy, wr_busy;
    logic         ctl_cache_en, ctl_cache_we;
    logic [127:0] ctl_cache_rdata;
    logic [1:0]   grant;
    logic         arb_err;

    psram_line_arbiter #(.MAX_VID_RUN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .mem_clk(mem_clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_line_rdata(cpu_line_rdata), .cpu_ack(cpu_ack),
        .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_buf_we(cpu_buf_we), .vid_buf_we(vid_buf_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .raddr(raddr), .waddr(waddr),
        .rd_busy(rd_busy), .wr_busy(wr_busy),
        .ctl_cache_en(ctl_cache_en), .ctl_cache_we(ctl_cache_we),
        .ctl_cache_rdata(ctl_cache_rdata), .grant(grant), .arb_err(arb_err)
    );

    always #5 mem_clk = ~mem_clk;

    // ---------------- controller model ----------------
    logic ctl_auto = 1'b0;
    logic force_en = 1'b0;
    logic busy     = 1'b0;
    logic cur_rd   = 1'b0;
    int   busy_len = 12;
    int   busy_cnt = 0;

    always @(posedge mem_clk) begin
        if (reset) begin
            busy     <= 1'b0;
            busy_cnt <= 0;
        end else if (ctl_auto) begin
            if (!busy && (mem_rd || mem_wr) && busy_cnt == 0) begin
                busy     <= 1'b1;
                busy_cnt <= busy_len;
                cur_rd   <= mem_rd;
            end else if (busy) begin
                if (busy_cnt == 1) busy <= 1'b0;
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    assign rd_busy      = busy & cur_rd;
    assign wr_busy      = busy & ~cur_rd;
    assign ctl_cache_en = force_en | (busy && busy_cnt >= 2 && busy_cnt <= 5);
    assign ctl_cache_we = force_en | (busy && cur_rd && busy_cnt >= 2 && busy_cnt <= 5);

    // ---------------- monitors ----------------
    int n_rd_cyc  = 0;
    int n_cpu_we  = 0;
    int n_vid_we  = 0;
    int n_cpu_ack = 0;
    int n_vid_ack = 0;
    int n_both    = 0;
    int n_order   = 0;
    int order [64];
    logic [1:0] prev_grant = 2'b00;

    // Grant-order codes: 1 = video, 2 = CPU write, 3 = CPU read.
    always @(negedge mem_clk) begin
        if (mem_rd)            n_rd_cyc++;
        if (cpu_buf_we)        n_cpu_we++;
        if (vid_buf_we)        n_vid_we++;
        if (cpu_ack)           n_cpu_ack++;
        if (vid_ack)           n_vid_ack++;
        if (mem_rd && mem_wr)  n_both++;
        if (grant != 2'b00 && prev_grant == 2'b00 && n_order < 64) begin
            order[n_order] = (grant == 2'b10) ? 1 : (mem_wr ? 2 : 3);
            n_order++;
        end
        prev_grant = grant;
    end

    // ---------------- helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic wait_ack(input bit vid, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge mem_clk);
            #1;
            if (vid ? vid_ack : cpu_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(input logic [1:0] g, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge mem_clk);
            #1;
            if (grant == g) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int b_rd, b_cwe, b_vwe, b_cack, b_both, b_ord, vid_before_cpu;
        bit seen_cpu;

        reset = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; vid_rd = 1'b0;
        cpu_addr = 18'd0; vid_addr = 18'd0;
        cpu_line_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ctl_auto = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check("rst_grant", grant, 2'b00);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_raddr", raddr, 18'd0);
        check("rst_waddr", waddr, 18'd0);
        check("rst_acks", {cpu_ack, vid_ack}, 2'b00);
        check("rst_arb_err", arb_err, 1'b0);

        // T1: single CPU read, busy held 128 cycles
        busy_len = 128;
        b_rd = n_rd_cyc; b_cwe = n_cpu_we; b_cack = n_cpu_ack;
        cpu_addr = 18'h00123;
        cpu_rd = 1'b1;
        wait_ack(1'b0, 300, ok);
        check("t1_ack_seen", ok, 1'b1);
        check("t1_busy_low_at_ack", rd_busy | wr_busy, 1'b0);
        check("t1_raddr", raddr, 18'h00123);
        check("t1_grant", grant, 2'b01);
        cpu_rd = 1'b0;
        step(1);
        check("t1_ack_one_cycle", cpu_ack, 1'b0);
        check("t1_grant_clear", grant, 2'b00);
        check("t1_mem_rd_cycles", n_rd_cyc - b_rd, 2);
        check("t1_cpu_buf_we", n_cpu_we - b_cwe, 4);
        check("t1_cpu_ack_count", n_cpu_ack - b_cack, 1);

        // T2: simultaneous write-back, fill and video
        busy_len = 12;
        step(2);
        b_ord = n_order; b_both = n_both; b_cwe = n_cpu_we; b_vwe = n_vid_we;
        cpu_addr = 18'h00010;
        vid_addr = 18'h3FFC0;
        cpu_wr = 1'b1; cpu_rd = 1'b1; vid_rd = 1'b1;
        wait_ack(1'b1, 100, ok);
        check("t2_vid_ack_seen", ok, 1'b1);
        check("t2_vid_raddr", raddr, 18'h3FFC0);
        vid_rd = 1'b0;
        wait_ack(1'b0, 100, ok);
        check("t2_wr_ack_seen", ok, 1'b1);
        check("t2_waddr", waddr, 18'h00010);
        cpu_wr = 1'b0;
        wait_ack(1'b0, 100, ok);
        check("t2_rd_ack_seen", ok, 1'b1);
        check("t2_raddr", raddr, 18'h00010);
        cpu_rd = 1'b0;
        step(2);
        check("t2_count", n_order - b_ord, 3);
        check("t2_first_video", order[b_ord], 1);
        check("t2_second_cpu_wr", order[b_ord + 1], 2);
        check("t2_third_cpu_rd", order[b_ord + 2], 3);
        check("t2_never_rd_and_wr", n_both - b_both, 0);
        check("t2_vid_buf_we", n_vid_we - b_vwe, 4);
        check("t2_cpu_buf_we", n_cpu_we - b_cwe, 4);

        // T3: routing of buffer strobes and write data
        force_en = 1'b1;
        #1;
        check("t3_idle_cpu_we", cpu_buf_we, 1'b0);
        check("t3_idle_vid_we", vid_buf_we, 1'b0);
        check("t3_rdata_pass", ctl_cache_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        force_en = 1'b0;
        vid_addr = 18'h0ABCD;
        vid_rd = 1'b1;
        wait_grant(2'b10, 10, ok);
        check("t3_vid_grant_seen", ok, 1'b1);
        force_en = 1'b1;
        #1;
        check("t3_vid_we_routed", vid_buf_we, 1'b1);
        check("t3_cpu_we_blocked", cpu_buf_we, 1'b0);
        force_en = 1'b0;
        wait_ack(1'b1, 100, ok);
        check("t3_vid_ack_seen", ok, 1'b1);
        vid_rd = 1'b0;
        step(2);

        // T4: video starvation limit
        b_ord = n_order;
        vid_before_cpu = -1;
        seen_cpu = 1'b0;
        ok = 1'b0;
        vid_addr = 18'h00001;
        cpu_addr = 18'h00002;
        vid_rd = 1'b1; cpu_rd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (cpu_ack && !seen_cpu) begin
                seen_cpu = 1'b1;
                vid_before_cpu = n_vid_ack;
                cpu_rd = 1'b0;
            end
            if (vid_ack && (n_order - b_ord) >= 6) begin
                vid_rd = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        check("t4_completed", ok, 1'b1);
        step(2);
        for (int i = 0; i < 4; i++) begin
            check("t4_video_run", order[b_ord + i], 1);
        end
        check("t4_cpu_after_run", order[b_ord + 4], 3);
        check("t4_video_resumes", order[b_ord + 5], 1);
        check("t4_grant_count", n_order - b_ord, 6);

        // T5: reset in the middle of BUSY
        busy_len = 40;
        cpu_addr = 18'h2AAAA;
        cpu_rd = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (busy && !mem_rd) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reached_busy", ok, 1'b1);
        step(3);
        b_cack = n_cpu_ack;
        reset = 1'b1;
        cpu_rd = 1'b0;
        step(1);
        reset = 1'b0;
        check("t5_grant", grant, 2'b00);
        check("t5_mem_rd", mem_rd, 1'b0);
        check("t5_raddr", raddr, 18'd0);
        check("t5_ack", {cpu_ack, vid_ack}, 2'b00);
        step(20);
        check("t5_no_ack", n_cpu_ack - b_cack, 0);
        busy_len = 12;
        cpu_addr = 18'h00055;
        cpu_rd = 1'b1;
        wait_ack(1'b0, 100, ok);
        check("t5_new_ack_seen", ok, 1'b1);
        check("t5_new_raddr", raddr, 18'h00055);
        cpu_rd = 1'b0;
        step(1);
        check("t5_new_ack_count", n_cpu_ack - b_cack, 1);

        // T6: controller still initialising, ISSUE must hold
        step(2);
        ctl_auto = 1'b0;
        b_cack = n_cpu_ack;
        cpu_addr = 18'h00003;
        cpu_wr = 1'b1;
        step(40);
        check("t6_mem_wr_held", mem_wr, 1'b1);
        check("t6_mem_rd_low", mem_rd, 1'b0);
        check("t6_grant", grant, 2'b01);
        check("t6_no_ack", n_cpu_ack - b_cack, 0);
        ctl_auto = 1'b1;
        wait_ack(1'b0, 100, ok);
        check("t6_ack_seen", ok, 1'b1);
        check("t6_waddr", waddr, 18'h00003);
        cpu_wr = 1'b0;
        step(2);

`ifdef ARB_TIMEOUT_EN
        // T7: ISSUE watchdog with busy never rising
        ctl_auto = 1'b0;
        b_rd = n_rd_cyc; b_cack = n_cpu_ack;
        cpu_addr = 18'h00007;
        cpu_rd = 1'b1;
        wait_ack(1'b0, 300, ok);
        check("t7_ack_seen", ok, 1'b1);
        check("t7_arb_err", arb_err, 1'b1);
        check("t7_mem_rd_dropped", mem_rd, 1'b0);
        cpu_rd = 1'b0;
        step(1);
        check("t7_mem_rd_cycles", n_rd_cyc - b_rd, TMO);
        check("t7_ack_count", n_cpu_ack - b_cack, 1);
        step(5);
        check("t7_arb_err_sticky", arb_err, 1'b1);
        ctl_auto = 1'b1;
`else
        check("arb_err_tied_low", arb_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
